// File: rtl/y_acc_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : y_acc_stage_if
// Brief    : Beat/result handshake bundle between the yAdder, y_acc_stage
//            and the downstream consumer of the accumulated total.
// Revision : 1.0 - initial release
// ============================================================================
interface y_acc_stage_if #(
    parameter int SIZE    = 32,
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic               opnd_msb;
    logic [SIZE-1:0]    sum;
    logic               cout;
    logic [SIZE-1:0]    acc;
    logic               out_valid;
    logic               out_ready;
    logic               carry_flag;
    logic               ovf_flag;
    logic [COUNT_W-1:0] count;

    modport master (
        output in_valid, in_last, opnd_msb, sum, cout, out_ready,
        input  in_ready, acc, out_valid, carry_flag, ovf_flag, count
    );

    modport slave (
        input  in_valid, in_last, opnd_msb, sum, cout, out_ready,
        output in_ready, acc, out_valid, carry_flag, ovf_flag, count
    );
endinterface
`default_nettype wire

// File: rtl/y_acc_stage.sv
`default_nettype none
// ============================================================================
// Module   : y_acc_stage
// Brief    : Accumulates yAdder sums beat by beat (acc feeds adder input b)
//            and hands the total plus sticky carry/overflow flags downstream.
//            Optional macro Y_ACC_SAT_EN: saturate acc on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module y_acc_stage #(
    parameter int SIZE    = 32,
    parameter int COUNT_W = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    y_acc_stage_if.slave bus
);
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]         r_state;
    logic [SIZE-1:0]    r_acc;
    logic               r_carry;
    logic               r_ovf;
    logic [COUNT_W-1:0] r_count;

    logic               w_ovf_term;
    logic               w_count_max;
    logic [SIZE-1:0]    w_acc_next;

    // Operands of equal sign producing a result of the other sign.
    assign w_ovf_term  = (bus.opnd_msb == r_acc[SIZE-1]) &&
                         (bus.sum[SIZE-1] != bus.opnd_msb);
    assign w_count_max = &r_count;

`ifdef Y_ACC_SAT_EN
    logic [SIZE-1:0] w_sat_val;
    assign w_sat_val  = bus.opnd_msb ? {1'b1, {(SIZE-1){1'b0}}}
                                     : {1'b0, {(SIZE-1){1'b1}}};
    assign w_acc_next = w_ovf_term ? w_sat_val : bus.sum;
`else
    assign w_acc_next = bus.sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        r_acc   <= w_acc_next;
                        r_carry <= r_carry | bus.cout;
                        r_ovf   <= r_ovf | w_ovf_term;
                        r_count <= w_count_max ? r_count : r_count + 1'b1;
                        if (bus.in_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_ACCUM;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_count <= '0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_ACCUM);
    assign bus.out_valid  = (r_state == ST_DONE);
    assign bus.acc        = r_acc;
    assign bus.carry_flag = r_carry;
    assign bus.ovf_flag   = r_ovf;
    assign bus.count      = r_count;
endmodule
`default_nettype wire

// File: tb/tb_y_acc_stage.sv
`default_nettype none
// Bench for y_acc_stage: random beat sequences through a behavioural adder,
// expected totals queued per transaction and checked by a result monitor.
module tb_y_acc_stage;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] acc;
        logic        carry;
        logic        ovf;
        logic [7:0]  count;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] operand;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_fail;
    bit          chk_clear;

    y_acc_stage_if #(.SIZE(32), .COUNT_W(8)) bus ();
    y_acc_stage_if #(.SIZE(32), .COUNT_W(2)) bus2 ();

    y_acc_stage #(.SIZE(32), .COUNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    y_acc_stage #(.SIZE(32), .COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Upstream yAdder: a = operand, b = acc, carry-in = 0.
    assign {bus.cout, bus.sum}   = {1'b0, operand} + {1'b0, bus.acc};
    assign bus.opnd_msb          = operand[31];
    assign {bus2.cout, bus2.sum} = {1'b0, 32'd1} + {1'b0, bus2.acc};
    assign bus2.opnd_msb         = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: signed/unsigned sums in wide integer arithmetic.
    function automatic exp_t model(input logic [31:0] ops[$]);
        exp_t        e;
        logic [32:0] u;
        longint      s;
        bit          o;
        int          cnt;
        e.acc = '0; e.carry = 1'b0; e.ovf = 1'b0; cnt = 0;
        foreach (ops[i]) begin
            u = {1'b0, ops[i]} + {1'b0, e.acc};
            s = longint'($signed(ops[i])) + longint'($signed(e.acc));
            o = (s > SMAX) || (s < SMIN);
            e.carry = e.carry | u[32];
            e.ovf   = e.ovf | o;
`ifdef Y_ACC_SAT_EN
            if (o) e.acc = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else   e.acc = u[31:0];
`else
            e.acc = u[31:0];
`endif
            cnt = (cnt < 255) ? cnt + 1 : 255;
        end
        e.count = 8'(cnt);
        return e;
    endfunction

    task automatic run_txn(input logic [31:0] ops[$], input int stall);
        int k;
        bit hs;
        sb_q.push_back(model(ops));
        for (int i = 0; i < ops.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                operand      = $urandom;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_last  = (i == ops.size() - 1);
            operand      = ops[i];
            @(posedge clk); #1;
        end
        k  = 0;
        hs = 1'b0;
        while (!hs) begin
            bus.out_ready = (k >= stall);
            bus.in_valid  = 1'b1;
            bus.in_last   = 1'($urandom_range(0, 1));
            operand       = $urandom;
            @(negedge clk);
            if (k == 0) chk("out_valid_latency", {bus.out_valid, bus.in_ready}, 64'b10);
            hs = bus.out_valid && bus.out_ready;
            if (!bus.out_valid) begin
                chk("done_hold", bus.out_valid, 1'b1);
                hs = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_clear = 1'b0;
            end else begin
                if (chk_clear) begin
                    chk("handoff_clear", {bus.acc, 8'(bus.count), bus.carry_flag, bus.ovf_flag,
                                          bus.in_ready, bus.out_valid}, {32'd0, 8'd0, 4'b0010});
                    chk_clear = 1'b0;
                end
                if (bus.out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", bus.out_valid, 1'b0);
                    end else begin
                        chk("result_acc",   bus.acc,        sb_q[0].acc);
                        chk("result_carry", bus.carry_flag, sb_q[0].carry);
                        chk("result_ovf",   bus.ovf_flag,   sb_q[0].ovf);
                        chk("result_count", bus.count,      sb_q[0].count);
                        chk("done_in_ready", bus.in_ready,  1'b0);
                        if (bus.out_ready) begin
                            void'(sb_q.pop_front());
                            chk_clear = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] ops[$];
        n_cmp = 0; n_fail = 0; chk_clear = 1'b0;
        rst = 1'b1; operand = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {bus.acc, 8'(bus.count), bus.carry_flag, bus.ovf_flag,
                            bus.in_ready, bus.out_valid}, {32'd0, 8'd0, 4'b0010});

        // Reset in the middle of an accumulation.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; operand = 32'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("acc_after_beat", bus.acc, 32'd5);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_reset", {bus.acc, 8'(bus.count), bus.carry_flag, bus.ovf_flag,
                          bus.in_ready, bus.out_valid}, {32'd0, 8'd0, 4'b0010});

        ops = {}; ops.push_back(32'd10); ops.push_back(32'd20); ops.push_back(32'd30);
        run_txn(ops, 0);
        ops = {}; ops.push_back(32'hFFFF_FFFF); ops.push_back(32'd2);
        run_txn(ops, 1);
        ops = {}; ops.push_back(32'h7FFF_FFFF); ops.push_back(32'd1);
        run_txn(ops, 0);
        ops = {}; ops.push_back(32'h8000_0000); ops.push_back(32'hFFFF_FFFF); ops.push_back(32'h8000_0000);
        run_txn(ops, 0);
        ops = {}; ops.push_back(32'd77);
        run_txn(ops, 0);
        ops = {}; ops.push_back(32'd3); ops.push_back(32'd4);
        run_txn(ops, 5);

        for (int t = 0; t < 30; t++) begin
            ops = {};
            for (int b = 0; b < int'($urandom_range(1, 10)); b++) begin
                case ($urandom_range(0, 3))
                    0: ops.push_back($urandom);
                    1: ops.push_back(32'($urandom_range(0, 255)));
                    2: ops.push_back(32'h7FFF_FF00 + 32'($urandom_range(0, 255)));
                    default: ops.push_back(32'h8000_0000 + 32'($urandom_range(0, 255)));
                endcase
            end
            run_txn(ops, int'($urandom_range(0, 3)));
        end

        ops = {};
        for (int b = 0; b < 260; b++) ops.push_back(32'($urandom_range(0, 15)));
        run_txn(ops, 0);

        // Narrow counter instance: five beats of 1 saturate a 2-bit count.
        for (int b = 0; b < 5; b++) begin
            bus2.in_valid = 1'b1;
            bus2.in_last  = (b == 4);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        @(negedge clk);
        chk("sat_count", bus2.count, 2'd3);
        chk("sat_acc", bus2.acc, 32'd5);
        chk("sat_out_valid", bus2.out_valid, 1'b1);
        @(posedge clk); #1 bus2.out_ready = 1'b1;
        @(posedge clk); #1 bus2.out_ready = 1'b0;
        @(negedge clk);
        chk("sat_clear", {bus2.acc, 2'(bus2.count), bus2.out_valid}, {32'd0, 2'd0, 1'b0});

        for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/y_acc_stage.md
Name: y_acc_stage

Overview:
- Sequential accumulation stage directly downstream of the SIZE-bit ripple adder (yAdder).
- Registers the adder's sum and carry-out on each accepted beat, and feeds the accumulator back as the adder's b operand.
- Presents the final total plus sticky flags on a valid/ready output port when the upstream marks the last beat.
- Upstream wiring: adder a = new operand, b = acc, carry = 0.

Parameters:
- SIZE, 32, datapath width; matches the adder.
- COUNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat.
- in_last  input  1  the beat is the final term of the current sum.
- opnd_msb  input  1  bit SIZE-1 of the operand driven on adder input a.
- sum  input  SIZE  adder output z.
- cout  input  1  adder carry-out.
- acc  output  SIZE  accumulator register; drives adder input b.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- carry_flag  output  1  sticky OR of cout over the accepted beats.
- ovf_flag  output  1  sticky signed overflow.
- count  output  COUNT_W  number of beats accepted; saturating.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: acc=0, carry_flag=0, ovf_flag=0, count=0, out_valid=0, state=ACCUM.
- rst overrides all other inputs in any state, including in the middle of an accumulation or while holding a result.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid=1 on a clock edge.
  - On acceptance: acc<=sum; carry_flag<=carry_flag|cout; count<=count+1, held at 2^COUNT_W-1 once reached.
  - On acceptance: ovf_flag<=ovf_flag|((opnd_msb==acc[SIZE-1]) && (sum[SIZE-1]!=opnd_msb)), where acc is the pre-update value.
  - If the accepted beat has in_last=1, go to DONE.
- State DONE:
  - in_ready=0, out_valid=1.
  - acc, flags and count are held stable.
  - in_valid is ignored; no data is consumed.
  - On out_valid&&out_ready: go to ACCUM and clear acc, carry_flag, ovf_flag and count to 0 on the same edge.
  - A new beat is first accepted the cycle after the handoff; a simultaneous in_valid on the handoff edge is not taken.
- Latency:
  - An accepted beat is reflected in acc on the next cycle.
  - out_valid rises the cycle after the last beat is accepted.
  - An in_last beat accepted as the first beat gives a one-term result.
- Wrap-around: with the optional feature disabled, acc wraps modulo 2^SIZE; carry_flag and ovf_flag record the event.
- Combinational outputs: in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- Downstream stall: out_ready=0 in DONE holds everything indefinitely.

Optional Feature:
- Macro: Y_ACC_SAT_EN.
- Defined: on a beat whose signed-overflow term is 1, acc loads the saturated value instead of sum.
  - Positive saturation (opnd_msb=0): 0x7FFF_FFFF for SIZE=32.
  - Negative saturation (opnd_msb=1): 0x8000_0000.
  - ovf_flag still sets.
  - Once saturated, further same-sign beats keep acc at the limit.
- Undefined: acc<=sum always (wrapping). No saturation logic is synthesised.

Test Plan:
- Reset: assert rst mid-accumulation after acc=5 -> next cycle acc=0, count=0, flags=0, in_ready=1, out_valid=0.
- Three-beat sum, operands 10, 20, 30, in_last on the third -> acc=60, count=3, carry_flag=0, ovf_flag=0, out_valid=1 the cycle after the third beat.
- Unsigned carry: operands 0xFFFF_FFFF then 2 (last) -> acc=0x0000_0001, carry_flag=1, ovf_flag=0.
- Signed overflow: 0x7FFF_FFFF then 1 (last) -> without the macro acc=0x8000_0000; with Y_ACC_SAT_EN acc=0x7FFF_FFFF; ovf_flag=1 in both builds.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0 throughout and acc unchanged; raise out_ready -> next cycle acc=0, count=0, state=ACCUM.
- Count saturation with COUNT_W=2: five beats of 1, last on the fifth -> count=3, acc=5.
